// File: rtl/seq_alu_if.sv
// ---------------------------------------------------------------------------
// seq_alu_if
// Request/response bundle between the EX stage and the sequential ALU.
//
//   start        master -> slave  request, sampled only while busy = 0
//   alu_code     master -> slave  5-bit operation select
//   data1/data2  master -> slave  operands A and B (WIDTH bits)
//   busy         slave -> master  iterative operation in progress
//   done         slave -> master  one-cycle pulse, result fields valid
//   result       slave -> master  primary result (WIDTH bits)
//   result_hi    slave -> master  product upper half / remainder / 0
//   zero         slave -> master  result == 0
//   div_by_zero  slave -> master  last divide had data2 == 0
// ---------------------------------------------------------------------------
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [4:0]       alu_code;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             div_by_zero;

  modport master (
    output start, alu_code, data1, data2,
    input  busy, done, result, result_hi, zero, div_by_zero
  );

  modport slave (
    input  start, alu_code, data1, data2,
    output busy, done, result, result_hi, zero, div_by_zero
  );
endinterface

// File: rtl/seq_alu.sv
// ---------------------------------------------------------------------------
// seq_alu
// Multi-cycle ALU for the EX stage. Single-cycle operations (add, sub, mov,
// pass, compares) complete one clock after the request is taken; multiply
// (shift-add) and divide (restoring) iterate once per clock for WIDTH clocks.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_alu_if slave: start/alu_code/data1/data2 in,
//          busy/done/result/result_hi/zero/div_by_zero out
//
// Timing (request taken at edge E)
//   single-cycle op : done high after edge E+1
//   mult / div      : busy high from E until edge E+WIDTH, done after E+WIDTH+1
// A new request is accepted in any cycle where busy = 0, so single-cycle ops
// stream at one per clock.
// ---------------------------------------------------------------------------
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_MOV   = 5'b00010;
  localparam logic [4:0] OP_MULT  = 5'b00011;
  localparam logic [4:0] OP_DIV   = 5'b00100;
  localparam logic [4:0] OP_PASS  = 5'b00101;
  localparam logic [4:0] OP_SLE   = 5'b00110;
  localparam logic [4:0] OP_SGE   = 5'b00111;
  localparam logic [4:0] OP_SLT_S = 5'b01000;
  localparam logic [4:0] OP_SGT_S = 5'b01001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Captured request
  logic [4:0]         op_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;        // divisor already forced to 1 when B == 0
  logic               dbz_pend_reg;

  // Iteration state: acc_reg is the 2*WIDTH product shift register for
  // multiply; for divide its low half shifts the dividend out and the
  // quotient in, while rem_reg keeps the remainder.
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [CNT_W-1:0]   cnt_reg;

  // Registered outputs
  logic [WIDTH-1:0]   result_reg;
  logic [WIDTH-1:0]   result_hi_reg;
  logic               zero_reg;
  logic               div_by_zero_reg;
  logic               done_reg;

  // Control decodes
  logic               busy_int;
  logic               accept;
  logic               finish;
  logic               start_multi;
  logic               start_div_zero;
  logic               last_iter;

  // Datapath intermediates
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     part_rem;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   single_res;
  logic [WIDTH-1:0]   fin_lo;
  logic [WIDTH-1:0]   fin_hi;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  assign start_multi    = (bus.alu_code == OP_MULT) || (bus.alu_code == OP_DIV);
  assign start_div_zero = (bus.alu_code == OP_DIV) && (bus.data2 == '0);
  assign last_iter      = (cnt_reg == CNT_W'(WIDTH - 1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (bus.start) begin
          state_next = start_multi ? RUN : DONE;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: output decode
  // DONE is the cycle in which the finished operation is committed to the
  // output registers, so done itself rises one edge after entering DONE.
  // -------------------------------------------------------------------------
  always_comb begin
    busy_int = (state_reg == RUN);
    accept   = bus.start && (state_reg != RUN);
    finish   = (state_reg == DONE);
  end

  // -------------------------------------------------------------------------
  // Request capture
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      dbz_pend_reg <= 1'b0;
    end else if (accept) begin
      op_reg       <= bus.alu_code;
      a_reg        <= bus.data1;
      b_reg        <= start_div_zero ? WIDTH'(1) : bus.data2;
      dbz_pend_reg <= start_div_zero;
    end
  end

  // -------------------------------------------------------------------------
  // One multiply step: add the multiplicand into the upper half when the
  // current multiplier bit is set, then shift the whole register right.
  // -------------------------------------------------------------------------
  always_comb begin
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
             + (acc_reg[0] ? {1'b0, a_reg} : {(WIDTH + 1){1'b0}});
    mul_next = {mul_sum, acc_reg[WIDTH-1:1]};
  end

  // -------------------------------------------------------------------------
  // One restoring-divide step on the WIDTH+1 bit partial remainder. The
  // difference only needs WIDTH bits: it is kept only when it is
  // non-negative, and then it is smaller than the divisor.
  // -------------------------------------------------------------------------
  always_comb begin
    part_rem = {rem_reg, acc_reg[WIDTH-1]};
    div_ge   = (part_rem >= {1'b0, b_reg});
    div_diff = part_rem[WIDTH-1:0] - b_reg;
    rem_next = div_ge ? div_diff : part_rem[WIDTH-1:0];
    quo_next = {acc_reg[WIDTH-2:0], div_ge};
  end

  // -------------------------------------------------------------------------
  // Iteration registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
      rem_reg <= '0;
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg <= '0;
      rem_reg <= '0;
      if (bus.alu_code == OP_MULT) begin
        acc_reg <= {{WIDTH{1'b0}}, bus.data2};
      end else begin
        acc_reg <= {{WIDTH{1'b0}}, bus.data1};
      end
    end else if (busy_int) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
      if (op_reg == OP_MULT) begin
        acc_reg <= mul_next;
      end else begin
        acc_reg <= {acc_reg[2*WIDTH-1:WIDTH], quo_next};
        rem_reg <= rem_next;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Single-cycle operations, evaluated from the captured operands
  // -------------------------------------------------------------------------
  always_comb begin
    single_res = '0;
    case (op_reg)
      OP_ADD:   single_res = a_reg + b_reg;
      OP_SUB:   single_res = a_reg - b_reg;
      OP_MOV:   single_res = a_reg;
      OP_PASS:  single_res = b_reg;
      OP_SLE:   single_res = WIDTH'(a_reg <= b_reg);
      OP_SGE:   single_res = WIDTH'(a_reg >= b_reg);
      OP_SLT_S: single_res = WIDTH'($signed(a_reg) < $signed(b_reg));
      OP_SGT_S: single_res = WIDTH'($signed(a_reg) > $signed(b_reg));
      default:  single_res = '0;
    endcase
  end

  // Final result selection
  always_comb begin
    fin_lo = single_res;
    fin_hi = '0;
    if (op_reg == OP_MULT) begin
      fin_lo = acc_reg[WIDTH-1:0];
      fin_hi = acc_reg[2*WIDTH-1:WIDTH];
    end else if (op_reg == OP_DIV) begin
      fin_lo = acc_reg[WIDTH-1:0];
      fin_hi = rem_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Output registers: updated only when an operation commits, so every
  // result field holds until the next done.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg      <= '0;
      result_hi_reg   <= '0;
      zero_reg        <= 1'b1;
      div_by_zero_reg <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      done_reg <= finish;
      if (finish) begin
        result_reg      <= fin_lo;
        result_hi_reg   <= fin_hi;
        zero_reg        <= (fin_lo == '0);
        div_by_zero_reg <= (op_reg == OP_DIV) && dbz_pend_reg;
      end
    end
  end

  assign bus.busy        = busy_int;
  assign bus.done        = done_reg;
  assign bus.result      = result_reg;
  assign bus.result_hi   = result_hi_reg;
  assign bus.zero        = zero_reg;
  assign bus.div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_seq_alu.sv
// ---------------------------------------------------------------------------
// tb_seq_alu
// Drives a WIDTH=32 and a WIDTH=8 instance of seq_alu with directed vectors.
// A transaction-level model (plain arithmetic plus a queue of pending
// results) predicts done/busy/result fields for every cycle; directed
// vectors additionally carry hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_seq_alu;

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_MOV   = 5'b00010;
  localparam logic [4:0] OP_MULT  = 5'b00011;
  localparam logic [4:0] OP_DIV   = 5'b00100;
  localparam logic [4:0] OP_PASS  = 5'b00101;
  localparam logic [4:0] OP_SLE   = 5'b00110;
  localparam logic [4:0] OP_SGE   = 5'b00111;
  localparam logic [4:0] OP_SLT_S = 5'b01000;
  localparam logic [4:0] OP_SGT_S = 5'b01001;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) bus32 ();
  seq_alu_if #(.WIDTH(8))  bus8 ();

  seq_alu #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  seq_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  int checks = 0;
  int errors = 0;

  // ---------------- transaction model ----------------
  typedef struct {
    int          due;
    logic [63:0] lo;
    logic [63:0] hi;
    logic        dbz;
  } exp_t;

  exp_t        pq [2][$];
  int          widths     [2] = '{32, 8};
  int          free_edge  [2] = '{0, 0};
  int          busy_until [2] = '{-1, -1};
  logic [63:0] h_lo       [2] = '{64'd0, 64'd0};
  logic [63:0] h_hi       [2] = '{64'd0, 64'd0};
  logic        h_zero     [2] = '{1'b1, 1'b1};
  logic        h_dbz      [2] = '{1'b0, 1'b0};
  logic        done_exp   [2] = '{1'b0, 1'b0};
  int          n = 0;

  function automatic logic [63:0] mask_w(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic longint to_signed(input logic [63:0] v, input int w);
    if (v[w-1]) return longint'(v) - (longint'(1) << w);
    return longint'(v);
  endfunction

  function automatic void model_op(input int w, input logic [4:0] op,
                                   input logic [63:0] a_in, input logic [63:0] b_in,
                                   output logic [63:0] lo, output logic [63:0] hi,
                                   output logic dbz);
    logic [63:0] m, a, b, p, d;
    m   = mask_w(w);
    a   = a_in & m;
    b   = b_in & m;
    lo  = 64'd0;
    hi  = 64'd0;
    dbz = 1'b0;
    case (op)
      OP_ADD:   lo = (a + b) & m;
      OP_SUB:   lo = (a - b) & m;
      OP_MOV:   lo = a;
      OP_MULT: begin
        p  = a * b;
        lo = p & m;
        hi = (p >> w) & m;
      end
      OP_DIV: begin
        d   = (b == 64'd0) ? 64'd1 : b;
        lo  = a / d;
        hi  = a % d;
        dbz = (b == 64'd0);
      end
      OP_PASS:  lo = b;
      OP_SLE:   lo = (a <= b) ? 64'd1 : 64'd0;
      OP_SGE:   lo = (a >= b) ? 64'd1 : 64'd0;
      OP_SLT_S: lo = (to_signed(a, w) < to_signed(b, w)) ? 64'd1 : 64'd0;
      OP_SGT_S: lo = (to_signed(a, w) > to_signed(b, w)) ? 64'd1 : 64'd0;
      default:  lo = 64'd0;
    endcase
  endfunction

  function automatic void sample_in(input int k, output logic st, output logic [4:0] code,
                                    output logic [63:0] a, output logic [63:0] b);
    if (k == 0) begin
      st = bus32.start; code = bus32.alu_code;
      a = 64'(bus32.data1); b = 64'(bus32.data2);
    end else begin
      st = bus8.start; code = bus8.alu_code;
      a = 64'(bus8.data1); b = 64'(bus8.data2);
    end
  endfunction

  function automatic void get_out(input int k, output logic [63:0] lo, output logic [63:0] hi,
                                  output logic z, output logic dz, output logic bsy,
                                  output logic dn);
    if (k == 0) begin
      lo = 64'(bus32.result); hi = 64'(bus32.result_hi); z = bus32.zero;
      dz = bus32.div_by_zero; bsy = bus32.busy; dn = bus32.done;
    end else begin
      lo = 64'(bus8.result); hi = 64'(bus8.result_hi); z = bus8.zero;
      dz = bus8.div_by_zero; bsy = bus8.busy; dn = bus8.done;
    end
  endfunction

  // Model update on every rising edge
  always @(posedge clk) begin
    logic        st, multi, dbz;
    logic [4:0]  code;
    logic [63:0] a, b, lo, hi;
    exp_t        e;
    int          lat;
    n = n + 1;
    for (int k = 0; k < 2; k++) begin
      done_exp[k] = 1'b0;
      if (!rst_n) begin
        pq[k].delete();
        free_edge[k]  = 0;
        busy_until[k] = -1;
        h_lo[k] = 64'd0; h_hi[k] = 64'd0; h_zero[k] = 1'b1; h_dbz[k] = 1'b0;
      end else begin
        if (pq[k].size() > 0 && pq[k][0].due == n) begin
          e = pq[k].pop_front();
          h_lo[k] = e.lo; h_hi[k] = e.hi; h_dbz[k] = e.dbz;
          h_zero[k] = (e.lo == 64'd0);
          done_exp[k] = 1'b1;
        end
        sample_in(k, st, code, a, b);
        if (st && n >= free_edge[k]) begin
          model_op(widths[k], code, a, b, lo, hi, dbz);
          multi = (code == OP_MULT) || (code == OP_DIV);
          lat   = multi ? widths[k] + 1 : 1;
          e.due = n + lat; e.lo = lo; e.hi = hi; e.dbz = dbz;
          pq[k].push_back(e);
          free_edge[k] = n + lat;
          if (multi) busy_until[k] = n + widths[k];
        end
      end
    end
  end

  task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h", name, k, act, exp);
    end
  endtask

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    logic [63:0] lo, hi;
    logic        z, dz, bsy, dn;
    for (int k = 0; k < 2; k++) begin
      get_out(k, lo, hi, z, dz, bsy, dn);
      chk("done", k, 64'(dn), 64'(done_exp[k]));
      chk("busy", k, 64'(bsy), 64'(n < busy_until[k]));
      chk("result", k, lo, h_lo[k]);
      chk("result_hi", k, hi, h_hi[k]);
      chk("zero", k, 64'(z), 64'(h_zero[k]));
      chk("div_by_zero", k, 64'(dz), 64'(h_dbz[k]));
      if (dn) $display("txn dut%0d result=%h result_hi=%h zero=%0d dbz=%0d", k, lo, hi, z, dz);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int k, input logic [4:0] code, input logic [63:0] a,
                       input logic [63:0] b, input logic st);
    if (k == 0) begin
      bus32.alu_code = code; bus32.data1 = a[31:0]; bus32.data2 = b[31:0]; bus32.start = st;
    end else begin
      bus8.alu_code = code; bus8.data1 = a[7:0]; bus8.data2 = b[7:0]; bus8.start = st;
    end
  endtask

  task automatic set_start(input int k, input logic st);
    if (k == 0) bus32.start = st;
    else bus8.start = st;
  endtask

  // Issue one request, wait (bounded) for done and check literal expectations.
  task automatic run_op(input string name, input int k, input logic [4:0] code,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] e_lo, input logic [63:0] e_hi,
                        input logic e_zero, input logic e_dbz,
                        input int e_lat, input int e_busy);
    logic [63:0] lo, hi;
    logic        z, dz, bsy, dn, got;
    int          lat, busy_cnt;
    #1 drive(k, code, a, b, 1'b1);
    @(posedge clk);
    #1 set_start(k, 1'b0);
    lat = 0; busy_cnt = 0; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      get_out(k, lo, hi, z, dz, bsy, dn);
      if (dn) begin
        got = 1'b1;
      end else begin
        if (bsy) busy_cnt++;
        @(posedge clk);
        lat++;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s dut%0d timeout waiting for done", name, k);
    end else begin
      chk({name, "_latency"}, k, 64'(lat), 64'(e_lat));
      chk({name, "_busy_cycles"}, k, 64'(busy_cnt), 64'(e_busy));
      chk({name, "_result"}, k, lo, e_lo);
      chk({name, "_result_hi"}, k, hi, e_hi);
      chk({name, "_zero"}, k, 64'(z), 64'(e_zero));
      chk({name, "_dbz"}, k, 64'(dz), 64'(e_dbz));
    end
  endtask

  task automatic chk_reset_outputs(input string name, input int k);
    logic [63:0] lo, hi;
    logic        z, dz, bsy, dn;
    get_out(k, lo, hi, z, dz, bsy, dn);
    chk({name, "_result"}, k, lo, 64'd0);
    chk({name, "_result_hi"}, k, hi, 64'd0);
    chk({name, "_zero"}, k, 64'(z), 64'd1);
    chk({name, "_dbz"}, k, 64'(dz), 64'd0);
    chk({name, "_busy"}, k, 64'(bsy), 64'd0);
    chk({name, "_done"}, k, 64'(dn), 64'd0);
  endtask

  // Count done pulses over a number of cycles (checked against an expectation)
  task automatic count_done(input string name, input int k, input int cycles, input int e_cnt);
    logic [63:0] lo, hi;
    logic        z, dz, bsy, dn;
    int          cnt;
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      get_out(k, lo, hi, z, dz, bsy, dn);
      if (dn) cnt++;
    end
    chk(name, k, 64'(cnt), 64'(e_cnt));
  endtask

  initial begin
    logic [63:0] lo, hi;
    logic        z, dz, bsy, dn, got;

    drive(0, OP_ADD, 64'd0, 64'd0, 1'b0);
    drive(1, OP_ADD, 64'd0, 64'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("por", 0);
    chk_reset_outputs("por", 1);
    #1 rst_n = 1'b1;

    // ---- WIDTH=32: reset mid-stream ----
    run_op("mov32", 0, OP_MOV, 64'h1234, 64'h0, 64'h1234, 64'h0, 1'b0, 1'b0, 1, 0);
    #1 drive(0, OP_MULT, 64'h7, 64'h9, 1'b1);
    @(posedge clk);
    #1 set_start(0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst_mid32", 0);
    #1 rst_n = 1'b1;
    count_done("rst_mid32_no_done", 0, 40, 0);

    // ---- WIDTH=32: single ops and multiply ----
    run_op("add_wrap", 0, OP_ADD, 64'hFFFF_FFFF, 64'h1, 64'h0, 64'h0, 1'b1, 1'b0, 1, 0);
    run_op("sub_neg", 0, OP_SUB, 64'd5, 64'd7, 64'hFFFF_FFFE, 64'h0, 1'b0, 1'b0, 1, 0);
    run_op("mult32", 0, OP_MULT, 64'hFFFF_FFFF, 64'hFFFF_FFFF,
           64'h0000_0001, 64'hFFFF_FFFE, 1'b0, 1'b0, 33, 32);
    run_op("pass32", 0, OP_PASS, 64'h1, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 64'h0, 1'b0, 1'b0, 1, 0);

    // ---- WIDTH=8: divide, compares ----
    run_op("div8", 1, OP_DIV, 64'd200, 64'd7, 64'd28, 64'd4, 1'b0, 1'b0, 9, 8);
    run_op("div8_zero", 1, OP_DIV, 64'd57, 64'd0, 64'd57, 64'd0, 1'b0, 1'b1, 9, 8);
    run_op("add8", 1, OP_ADD, 64'd1, 64'd2, 64'd3, 64'd0, 1'b0, 1'b0, 1, 0);
    run_op("sle8", 1, OP_SLE, 64'h80, 64'h01, 64'd0, 64'd0, 1'b1, 1'b0, 1, 0);
    run_op("slt_s8", 1, OP_SLT_S, 64'h80, 64'h01, 64'd1, 64'd0, 1'b0, 1'b0, 1, 0);
    run_op("sgt_s8", 1, OP_SGT_S, 64'h7F, 64'hFF, 64'd1, 64'd0, 1'b0, 1'b0, 1, 0);
    run_op("sge8", 1, OP_SGE, 64'h80, 64'h01, 64'd1, 64'd0, 1'b0, 1'b0, 1, 0);
    run_op("bad_code", 1, 5'b01111, 64'd5, 64'd6, 64'd0, 64'd0, 1'b1, 1'b0, 1, 0);
    run_op("mult8", 1, OP_MULT, 64'hFF, 64'hFF, 64'h01, 64'hFE, 1'b0, 1'b0, 9, 8);

    // ---- start during RUN is ignored ----
    #1 drive(1, OP_MULT, 64'd13, 64'd11, 1'b1);
    @(posedge clk);
    #1 set_start(1, 1'b0);
    repeat (3) @(posedge clk);
    #1 drive(1, OP_ADD, 64'd1, 64'd1, 1'b1);
    @(posedge clk);
    #1 set_start(1, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      get_out(1, lo, hi, z, dz, bsy, dn);
      if (dn) got = 1'b1;
    end
    chk("ignored_got_done", 1, 64'(got), 64'd1);
    chk("ignored_result", 1, lo, 64'h8F);
    chk("ignored_result_hi", 1, hi, 64'h00);
    count_done("ignored_no_extra_done", 1, 6, 0);

    // ---- back-to-back single ops, start held through done cycles ----
    #1 drive(1, OP_ADD, 64'd10, 64'd20, 1'b1);
    @(posedge clk);
    #1 drive(1, OP_SUB, 64'd3, 64'd5, 1'b1);
    @(posedge clk);
    #1 drive(1, OP_MOV, 64'h55, 64'h0, 1'b1);
    @(posedge clk);
    #1 set_start(1, 1'b0);
    @(negedge clk);
    get_out(1, lo, hi, z, dz, bsy, dn);
    chk("b2b_sub_done", 1, 64'(dn), 64'd1);
    chk("b2b_sub_result", 1, lo, 64'hFE);
    @(negedge clk);
    get_out(1, lo, hi, z, dz, bsy, dn);
    chk("b2b_mov_done", 1, 64'(dn), 64'd1);
    chk("b2b_mov_result", 1, lo, 64'h55);

    // ---- request in the commit cycle right after RUN ----
    #1 drive(1, OP_MULT, 64'd3, 64'd5, 1'b1);
    @(posedge clk);
    #1 set_start(1, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      get_out(1, lo, hi, z, dz, bsy, dn);
      if (!bsy) got = 1'b1;
    end
    chk("gap_reached", 1, 64'(got), 64'd1);
    #1 drive(1, OP_ADD, 64'd7, 64'd9, 1'b1);
    @(posedge clk);
    #1 set_start(1, 1'b0);
    @(negedge clk);
    get_out(1, lo, hi, z, dz, bsy, dn);
    chk("gap_mult_done", 1, 64'(dn), 64'd1);
    chk("gap_mult_result", 1, lo, 64'd15);
    @(negedge clk);
    get_out(1, lo, hi, z, dz, bsy, dn);
    chk("gap_add_done", 1, 64'(dn), 64'd1);
    chk("gap_add_result", 1, lo, 64'd16);

    // ---- reset in the middle of a divide ----
    #1 drive(1, OP_DIV, 64'd100, 64'd3, 1'b1);
    @(posedge clk);
    #1 set_start(1, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst_mid8", 1);
    #1 rst_n = 1'b1;
    count_done("rst_mid8_no_done", 1, 12, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
